// File: rtl/memory_dump_reader_pkg.sv
// Shared types and sizing for the memory dump reader: state encoding and
// vector/lane geometry.
package memory_dump_reader_pkg;

  localparam int VEC_SIZE = 4;
  localparam int REG_SIZE = 8;
  localparam int LANE_W   = $clog2(VEC_SIZE);
  localparam int VEC_W    = VEC_SIZE * REG_SIZE;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } dump_state_e;

endpackage

// File: rtl/memory_dump_reader_serializer.sv
// Holds one captured vector word and streams it out lane by lane (lane 0 first)
// over a valid/ready handshake; flags acceptance of the final lane.
module vector_lane_serializer
  import memory_dump_reader_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [VEC_W-1:0]    vec_i,
  input  logic                send_i,
  input  logic                out_ready_i,
  output logic [REG_SIZE-1:0] out_data_o,
  output logic                out_valid_o,
  output logic                lane_last_o,
  output logic                last_accept_o,
  output logic [LANE_W-1:0]   lane_idx_o
);

  logic [VEC_SIZE-1:0][REG_SIZE-1:0] buf_q, buf_d;
  logic [LANE_W-1:0]                 idx_q, idx_d;
  logic                              handshake;

  assign handshake     = send_i & out_ready_i;
  assign lane_last_o   = (idx_q == LANE_W'(VEC_SIZE - 1));
  assign last_accept_o = handshake & lane_last_o;
  assign lane_idx_o    = idx_q;
  assign out_valid_o   = send_i;
  // Data is forced to zero when not offered so the bus is quiet outside SEND.
  assign out_data_o    = send_i ? buf_q[idx_q] : '0;

  always_comb begin
    buf_d = buf_q;
    idx_d = idx_q;
    if (load_i) begin
      buf_d = vec_i;
      idx_d = '0;
    end else if (handshake) begin
      idx_d = lane_last_o ? '0 : idx_q + LANE_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      idx_q <= '0;
    end else begin
      buf_q <= buf_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/memory_dump_reader.sv
// Dumps count vector words starting at start_addr from data memory and streams
// them to the host one lane per handshake.
module memory_dump_reader
  import memory_dump_reader_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_ni,
  input  logic                start_i,
  input  logic [REG_SIZE-1:0] start_addr_i,
  input  logic [REG_SIZE-1:0] count_i,
  output logic                mem_read_o,
  output logic [REG_SIZE-1:0] mem_address_o,
  input  logic [VEC_W-1:0]    mem_read_data_i,
  output logic [REG_SIZE-1:0] out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                done_o,
  output dump_state_e         state_o
);

  // Handshake: a lane transfers on any rising edge where out_valid_o and
  // out_ready_i are both high; while valid is high and ready low, out_data_o
  // and out_last_o hold their values and valid stays asserted.

  dump_state_e         state_q, state_d;
  logic [REG_SIZE-1:0] addr_q, addr_d;
  logic [REG_SIZE-1:0] remain_q, remain_d;
  logic                load, send;
  logic                lane_last, last_accept;
  logic [LANE_W-1:0]   lane_idx;

  vector_lane_serializer u_ser (
    .clk_i         (clk_i),
    .rst_ni        (reset_ni),
    .load_i        (load),
    .vec_i         (mem_read_data_i),
    .send_i        (send),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .lane_last_o   (lane_last),
    .last_accept_o (last_accept),
    .lane_idx_o    (lane_idx)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    mem_read_o = 1'b0;
    load       = 1'b0;
    send       = 1'b0;
    done_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d   = start_addr_i;
          remain_d = count_i;
          state_d  = (count_i != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        mem_read_o = 1'b1;
        state_d    = LOAD;
      end
      LOAD: begin
        load    = 1'b1;
        state_d = SEND;
      end
      SEND: begin
        send = 1'b1;
        if (last_accept) begin
          remain_d = remain_q - REG_SIZE'(1);
          if (remain_q == REG_SIZE'(1)) begin
            state_d = DONE;
          end else begin
            // Address wraps naturally modulo 2^REG_SIZE.
            addr_d  = addr_q + REG_SIZE'(1);
            state_d = FETCH;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
    end
  end

  assign mem_address_o = addr_q;
  assign out_last_o    = send & lane_last & (remain_q == REG_SIZE'(1));
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;

  logic unused_idx;
  assign unused_idx = ^lane_idx;

endmodule

// File: tb/tb_memory_dump_reader.sv
// Randomized bench for memory_dump_reader: a word-addressed memory model, an
// expected-lane queue built from the dump rules, and cycle-level timing checks.
module tb_memory_dump_reader;
  import memory_dump_reader_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  start_addr = '0;
  logic [7:0]  count = '0;
  logic        mem_read;
  logic [7:0]  mem_addr;
  logic [31:0] rd_data = '0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        done;
  dump_state_e state;

  memory_dump_reader dut (
    .clk_i           (clk),
    .reset_ni        (rst_n),
    .start_i         (start),
    .start_addr_i    (start_addr),
    .count_i         (count),
    .mem_read_o      (mem_read),
    .mem_address_o   (mem_addr),
    .mem_read_data_i (rd_data),
    .out_data_o      (out_data),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_last_o      (out_last),
    .busy_o          (busy),
    .done_o          (done),
    .state_o         (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: word per address, lane 0 in the low byte, read one cycle later
  logic [31:0] mem [256];
  always @(posedge clk) if (mem_read) rd_data <= mem[mem_addr];

  // scoreboard
  logic [8:0] exp_q[$];       // {last, data}
  logic [7:0] exp_addr_q[$];
  int checks = 0;
  int errors = 0;
  int hs_cnt = 0, mr_cnt = 0, done_cnt = 0;
  int first_valid_cyc = -1, done_cyc = -1;
  int ready_mode = 0;         // 0 always ready, 1 toggle, 2 random

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ready driver
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // monitor
  logic       prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check("hold_valid", 32'(out_valid), 32'd1);
          check("hold_data", 32'(out_data), 32'(prev_data));
          check("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (!out_valid) check("last_outside_send", 32'(out_last), 32'd0);
        if (mem_read) begin
          mr_cnt++;
          if (exp_addr_q.size() == 0) check("unexpected_read", 32'(mem_read), 32'd0);
          else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
        end
        if (out_valid && out_ready) begin
          hs_cnt++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'(out_valid), 32'd0);
          end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            check("data", 32'(out_data), 32'(e[7:0]));
            check("last", 32'(out_last), 32'(e[8]));
          end
        end
        if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  // reference model: the lane stream a dump of cnt words from addr must produce
  task automatic plan_dump(input logic [7:0] addr, input logic [7:0] cnt);
    for (int v = 0; v < int'(cnt); v++) begin
      logic [7:0]  a;
      logic [31:0] w;
      a = 8'((int'(addr) + v) % 256);
      exp_addr_q.push_back(a);
      w = mem[a];
      for (int l = 0; l < 4; l++)
        exp_q.push_back({(v == int'(cnt) - 1) && (l == 3), w[8*l +: 8]});
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(out_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  // driver: one full dump, optionally with a second start pulsed during SEND
  task automatic run_dump(input logic [7:0] addr, input logic [7:0] cnt,
                          input int mode, input bit inject);
    int start_cyc, snap_done, snap_hs, snap_mr;
    bit injected;
    ready_mode = mode;
    @(posedge clk);
    #1;
    plan_dump(addr, cnt);
    snap_done = done_cnt;
    snap_hs   = hs_cnt;
    snap_mr   = mr_cnt;
    first_valid_cyc = -1;
    injected  = 1'b0;
    start = 1'b1;
    start_addr = addr;
    count = cnt;
    start_cyc = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) check("busy_after_start", 32'(busy), 32'd1);
      if (inject && out_valid && !injected) begin
        start = 1'b1;
        start_addr = addr ^ 8'h55;
        count = 8'd3;
        injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done_cnt != snap_done) break;
    end
    start = 1'b0;
    check("done_seen", 32'(done_cnt - snap_done), 32'd1);
    check("done_pulse_width", 32'(done), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
    check("beats", 32'(hs_cnt - snap_hs), 32'(int'(cnt) * 4));
    check("reads", 32'(mr_cnt - snap_mr), 32'(cnt));
    check("exp_left", 32'(exp_q.size()), 32'd0);
    if (mode == 0) begin
      check("done_latency", 32'(done_cyc - start_cyc),
            (cnt == 0) ? 32'd1 : 32'(int'(cnt) * 6 + 1));
      if (cnt != 0) check("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
    end
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) mem[a] = $urandom;
    mem[8'h10] = 32'h0403_0201;
    mem[8'h11] = 32'h0807_0605;

    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("post_reset");

    run_dump(8'h10, 8'd2, 0, 1'b0);
    run_dump(8'h10, 8'd2, 1, 1'b0);
    run_dump(8'hFF, 8'd2, 0, 1'b0);
    run_dump(8'h40, 8'd0, 0, 1'b0);
    run_dump(8'h60, 8'd2, 0, 1'b1);

    // reset mid-SEND after two accepted lanes
    begin
      int snap_done, snap_hs;
      ready_mode = 0;
      @(posedge clk);
      #1;
      plan_dump(8'h20, 8'd2);
      snap_done = done_cnt;
      snap_hs = hs_cnt;
      start = 1'b1;
      start_addr = 8'h20;
      count = 8'd2;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (hs_cnt - snap_hs >= 2) break;
      end
      check("lanes_before_reset", 32'(hs_cnt - snap_hs), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      exp_addr_q.delete();
      check_quiet("abort");
      repeat (3) @(posedge clk);
      #3;
      rst_n = 1'b1;
      check("no_done_on_abort", 32'(done_cnt - snap_done), 32'd0);
    end
    run_dump(8'h30, 8'd1, 0, 1'b0);

    for (int k = 0; k < 8; k++)
      run_dump(8'($urandom_range(0, 255)), 8'($urandom_range(0, 4)),
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_dump_reader.md
# memory_dump_reader

Reads a contiguous range of vector words out of the data memory after the writeback stage has written them, and streams them to the host one scalar lane at a time over a valid/ready byte interface. It sits beside the data memory on its read side, typically active while the core is halted, and feeds the host/debug link. It is the reader counterpart to the writeback stage's memory writes.

## Interface
- vecSize, 4, lanes per vector word
- registerSize, 8, bits per lane and per memory address
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE
- startAddr  in  registerSize  first vector address, latched on accepted start
- count  in  registerSize  number of vector words to dump, latched on accepted start; 0 = empty dump
- memRead  out  1  high while an address is presented for reading
- memAddress  out  registerSize  data memory vector address
- memReadData  in  vecSize x registerSize  vector read data, valid the cycle after memRead
- outData  out  registerSize  current lane value
- outValid  out  1  outData valid
- outReady  in  1  sink accepts outData this cycle
- outLast  out  1  high with the final lane of the final vector
- busy  out  1  high from the cycle after accepted start until return to IDLE
- done  out  1  one-cycle pulse at dump completion

## Operation
- States: IDLE, FETCH, LOAD, SEND, DONE.
- IDLE: start=1 latches startAddr/count. count≠0 → FETCH; count=0 → DONE.
- FETCH: memRead=1, memAddress=current address; → LOAD.
- LOAD: capture memReadData into the lane buffer, lane index=0; → SEND.
- SEND: outValid=1, outData=buffer lane[index], lane 0 first. Handshake = outValid&outReady. On handshake with index<vecSize-1: index+1. On handshake with index=vecSize-1: decrement remaining; remaining now 0 → DONE, else address+1 → FETCH.
- DONE: done=1 for one cycle; → IDLE.
- Address arithmetic is modulo 2^registerSize: 0xFF+1 wraps to 0x00.
- outLast=1 only while index=vecSize-1 and remaining=1.
- start while busy: ignored, latched values unchanged.
- outData/outLast stable while outValid=1 and outReady=0.
- Reset asserted at any point (including mid-SEND): immediate return to IDLE, stream aborted, no done pulse.

## Timing
- Reset values: memRead=0, memAddress=0, outData=0, outValid=0, outLast=0, busy=0, done=0.
- start at cycle T (count≠0): FETCH at T+1, LOAD at T+2, first outValid at T+3.
- With outReady held high: one lane per cycle; 2-cycle bubble (FETCH, LOAD) between vectors; N vectors take N·(vecSize+2) cycles from T+1 to last handshake; done in the following cycle.
- count=0: DONE at T+1, done pulse at T+1, no memRead, no outValid.
- Next start is accepted in the cycle after done (IDLE).
- outputs outside SEND: outValid=0, outLast=0; memRead=0 outside FETCH.

## Structure
- Shared package: state enum typedef (IDLE, FETCH, LOAD, SEND, DONE) and the lane-index width constant $clog2(vecSize).
- One sub-module: vector_lane_serializer, which holds the captured vector, the lane index, and the outValid/outReady handshake, and reports last-lane acceptance to the top FSM.

## Test plan
- Memory 0x10={01,02,03,04}, 0x11={05,06,07,08}, start startAddr=0x10 count=2, outReady=1 → bytes 01..08 in order, outLast only with 08, done 1 cycle after 08 is accepted, busy low the cycle after done.
- Same as the first test, but outReady toggles 1/0 every cycle → identical byte sequence, outData held stable in stalled cycles, no byte duplicated or dropped.
- startAddr=0xFF count=2 → memAddress sequence 0xFF then 0x00, eight lanes streamed.
- count=0 → done pulse at T+1, memRead and outValid never asserted.
- Second start pulsed during SEND with different startAddr → ignored, first dump completes unchanged.
- reset pulled low mid-SEND after 2 lanes → all outputs zero immediately, no done; new start after release streams from its own startAddr.
